divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential restoring shift-subtract divider for 16-bit unsigned operands; it is the inverse companion of the shift-add multiplier in the Q16 arithmetic unit.
- mode=0 performs integer division: num1 / num2.
- mode=1 performs Q0.16 fractional division: (num1<<16) / num2. This undoes the multiplier's high-half result.
- Uses the same start/rdy/work handshake as the multiplier, so the sequencer drives both units identically.

Parameters:
- W, 16, operand/result width.
- CW, 6, iteration counter width; must hold 2*W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- mode  input  1  0 = integer, 1 = Q0.16 fractional; latched at start.
- num1  input  W  dividend; latched at start.
- num2  input  W  divisor; latched at start.
- result  output  W  quotient; held after completion.
- remainder  output  W  final remainder; held after completion.
- rdy  output  1  one-cycle completion pulse.
- work  output  1  busy flag.
- dz  output  1  divide-by-zero flag for the last operation; held.
- ovf  output  1  quotient overflow flag for the last operation (mode=1 only); held.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE.
  - result, remainder, dz, ovf, work, rdy all 0.
  - All internal registers 0.
  - Reset mid-operation aborts without a rdy pulse.
- States: IDLE, SHIFT, TRY, FIN.
- Datapath:
  - D: 32-bit dividend shift register.
  - R: 17-bit partial remainder.
  - Q: 32-bit quotient.
  - V: W-bit divisor.
  - cnt: CW-bit counter.
- IDLE, start=1:
  - Latch D = mode ? {num1,16'd0} : {16'd0,num1}; V=num2; m=mode.
  - Clear R=0, Q=0, cnt=0.
  - result, remainder, dz, ovf are cleared to 0 in this cycle.
  - work=1 combinationally in this cycle, then registered.
  - If num2==0: next state = FIN with dz pending. Otherwise next state = SHIFT.
- SHIFT:
  - R = {R[15:0], D[31]}; D = D<<1; Q = Q<<1.
  - Next state = TRY.
- TRY:
  - If R >= {1'b0,V}: R = R - V and Q[0] = 1.
  - cnt = cnt+1.
  - If cnt == 31 before the increment (i.e. 32 iterations done), next = FIN; else next = SHIFT.
- FIN:
  - rdy=1 for this cycle only; work=0 combinationally; next state = IDLE.
  - dz case: result=16'hFFFF, remainder=num1 as latched, dz=1, ovf=0.
  - Otherwise:
    - If Q[31:16] != 0: ovf=1 and result=16'hFFFF (saturated).
    - Else: result=Q[15:0].
    - remainder=R[15:0].
- Overflow range:
  - mode=0 can never overflow.
  - mode=1 overflows iff num1 >= num2.
- Latency, measured in clocks after the edge that samples start:
  - Normal operation: 64 cycles of SHIFT/TRY, then rdy is high in cycle 65.
  - Divide by zero: rdy is high in cycle 1.
- Back-to-back operation: the earliest next start is accepted in the IDLE cycle that follows FIN.
- start while state != IDLE is ignored; latched operands are unaffected.
- Operand changes after the start cycle have no effect.
- result, remainder, dz and ovf hold their values until the next accepted start or reset.
- Truncation: the quotient is truncated toward zero, never rounded.

Decomposition:
- Shared package (q16_pkg), holding:
  - State localparams IDLE/SHIFT/TRY/FIN (3-bit, matching the multiplier encoding width).
  - W=16.
  - MODE_INT=0, MODE_Q16=1.
  - SAT_MAX=16'hFFFF.
- Optional sub-module div_step: a combinational compare/subtract on a 17-bit R and a W-bit V, producing a new R and a quotient bit.
- Everything else stays in one module.

Test Plan:
- mode=0, num1=100, num2=7, start pulse:
  - rdy exactly 65 cycles after the start edge.
  - result=14, remainder=2, dz=0, ovf=0.
  - work=1 throughout the operation.
- mode=1, num1=16'h4000, num2=16'h8000 → result=16'h8000, ovf=0.
- mode=1, num1=16'h8000, num2=16'h4000 → ovf=1, result=16'hFFFF, rdy after 65 cycles.
- Divide by zero: mode=0, num1=1234, num2=0 → rdy 1 cycle after start; dz=1, result=16'hFFFF, remainder=1234.
- Start and operand changes during busy: start=1 with num1=5, num2=1 issued at cycle 10 of a 100/7 operation → ignored; the first result is still 14/2; a new start in IDLE after FIN yields 5/0.
- Reset mid-operation: rst=1 at cycle 30 → all outputs 0 and no rdy pulse; the next start computes 65535/255 → result=257, remainder=0.

Source files
------------

// File: rtl/q16_pkg.sv
// Shared definitions for the Q16 arithmetic unit (multiplier and divider).
// Holds the FSM state encoding, the data width, the mode encodings
// and the saturation value used when a quotient does not fit.
package q16_pkg;

  localparam int W = 16;

  // 3-bit state encoding, shared width with the multiplier
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] TRY   = 3'd2;
  localparam logic [2:0] FIN   = 3'd3;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_Q16 = 1'b1;

  localparam logic [W-1:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the sequencer and the divider.
//
// Handshake: the sequencer raises start for one or more cycles with mode,
// num1 and num2 valid; the divider accepts it only in the cycle it is idle
// (work is low before that cycle) and samples all operands on that edge.
// work is high from the accepting cycle until the completion cycle; rdy
// pulses for exactly one cycle at completion, and result/remainder/dz/ovf
// are valid in that cycle and stay stable until the next accepted start.
//
// Ports (master = sequencer, slave = divider):
//   start, mode, num1, num2     : master -> slave
//   result, remainder, rdy,
//   work, dz, ovf               : slave  -> master
interface divider_if #(
  parameter int W = 16
);
  logic         start;
  logic         mode;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         rdy;
  logic         work;
  logic         dz;
  logic         ovf;

  modport master (
    output start, mode, num1, num2,
    input  result, remainder, rdy, work, dz, ovf
  );

  modport slave (
    input  start, mode, num1, num2,
    output result, remainder, rdy, work, dz, ovf
  );
endinterface

// File: rtl/divider_step.sv
// One restoring-division step: compares the (already shifted) partial
// remainder against the divisor and subtracts when it fits.
//   r_in  : 17-bit partial remainder after the shift-in of the next bit
//   v     : divisor
//   r_out : remainder after the conditional subtract
//   q_bit : quotient bit produced by this step
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   r_in,
  input  logic [W-1:0] v,
  output logic [W:0]   r_out,
  output logic         q_bit
);
  assign q_bit = (r_in >= {1'b0, v});
  assign r_out = q_bit ? (r_in - {1'b0, v}) : r_in;
endmodule

// File: rtl/divider.sv
// Sequential restoring shift-subtract divider, 16-bit unsigned.
//   mode 0 : integer division        num1 / num2
//   mode 1 : Q0.16 fractional        (num1 << 16) / num2
// Each of the 32 iterations spends one cycle in SHIFT and one in TRY,
// followed by a single FIN cycle in which rdy pulses.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : divider_if slave (start/mode/num1/num2 in;
//               result/remainder/rdy/work/dz/ovf out)
//   dbg_state : current FSM state
module divider #(
  parameter int W  = 16,
  parameter int CW = 6
) (
  input  logic       clk,
  input  logic       rst,
  divider_if.slave   bus,
  output logic [2:0] dbg_state
);
  import q16_pkg::*;

  logic [2:0]     state;
  logic [2*W-1:0] d_q;      // dividend shift register
  logic [2*W-1:0] q_q;      // quotient
  logic [W:0]     r_q;      // partial remainder
  logic [W-1:0]   v_q;      // divisor
  logic [W-1:0]   n1_q;     // latched num1, reported as remainder on dz
  logic           m_q;
  logic           dz_p;     // divide by zero pending for this operation
  logic [CW-1:0]  cnt;

  logic [W-1:0]   result_q, rem_q;
  logic           dz_q, ovf_q;

  logic [W:0]     step_r;
  logic           step_q;
  logic           is_fin;
  logic           fin_ovf;
  logic [W-1:0]   fin_result, fin_rem;

  div_step #(.W(W)) u_step (
    .r_in  (r_q),
    .v     (v_q),
    .r_out (step_r),
    .q_bit (step_q)
  );

  // Final values are presented combinationally during FIN so they are valid
  // alongside rdy, then captured into the hold registers on the FIN edge.
  assign is_fin     = (state == FIN);
  assign fin_ovf    = !dz_p && (m_q == MODE_Q16) && (q_q[2*W-1:W] != '0);
  assign fin_result = (dz_p || fin_ovf) ? SAT_MAX : q_q[W-1:0];
  assign fin_rem    = dz_p ? n1_q : r_q[W-1:0];

  assign bus.result    = is_fin ? fin_result : result_q;
  assign bus.remainder = is_fin ? fin_rem    : rem_q;
  assign bus.dz        = is_fin ? dz_p       : dz_q;
  assign bus.ovf       = is_fin ? fin_ovf    : ovf_q;
  assign bus.rdy       = is_fin;
  // Busy as soon as a start is accepted; drops already in the FIN cycle.
  assign bus.work      = (state == IDLE) ? bus.start : !is_fin;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      v_q      <= '0;
      n1_q     <= '0;
      m_q      <= 1'b0;
      dz_p     <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            d_q      <= (bus.mode == MODE_INT) ? {{W{1'b0}}, bus.num1}
                                               : {bus.num1, {W{1'b0}}};
            v_q      <= bus.num2;
            n1_q     <= bus.num1;
            m_q      <= bus.mode;
            r_q      <= '0;
            q_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dz_p     <= (bus.num2 == '0);
            state    <= (bus.num2 == '0) ? FIN : SHIFT;
          end
        end
        SHIFT: begin
          r_q   <= {r_q[W-1:0], d_q[2*W-1]};
          d_q   <= d_q << 1;
          q_q   <= q_q << 1;
          state <= TRY;
        end
        TRY: begin
          r_q    <= step_r;
          q_q[0] <= step_q;
          cnt    <= cnt + 1'b1;
          state  <= (cnt == CW'(2*W-1)) ? FIN : SHIFT;
        end
        FIN: begin
          result_q <= fin_result;
          rem_q    <= fin_rem;
          dz_q     <= dz_p;
          ovf_q    <= fin_ovf;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: latency, integer and Q0.16 results,
// overflow saturation, divide by zero, ignored start while busy and
// reset in the middle of an operation.
module tb_divider;
  import q16_pkg::*;

  localparam int TW = 16;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  divider_if #(.W(TW)) bus();

  divider #(.W(TW), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present a start for exactly one edge; returns #1 after that edge
  task automatic drive_start(input logic m, input logic [TW-1:0] a, input logic [TW-1:0] b);
    bus.mode  = m;
    bus.num1  = a;
    bus.num2  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // waits (bounded) for rdy; lat counts cycles since the start edge
  task automatic wait_rdy(input int first, output int lat, output bit work_ok);
    lat = first;
    work_ok = 1'b1;
    while (bus.rdy !== 1'b1 && lat < 200) begin
      if (bus.work !== 1'b1) work_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_op(input logic [TW-1:0] res, input logic [TW-1:0] rem);
    exp_q.push_back(res);
    exp_q.push_back(rem);
  endtask

  task automatic check_op(input string tag);
    logic [TW-1:0] e_res, e_rem;
    e_res = exp_q.pop_front();
    e_rem = exp_q.pop_front();
    check({tag, "_result"}, bus.result, e_res);
    check({tag, "_remainder"}, bus.remainder, e_rem);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit wok;
    bit saw_rdy;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.num1 = '0;
    bus.num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 16'd0);
    check("rst_remainder", bus.remainder, 16'd0);
    check("rst_rdy", bus.rdy, 1'b0);
    check("rst_work", bus.work, 1'b0);
    check("rst_dz", bus.dz, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 100 / 7 = 14 rem 2 (truncated)
    expect_op(16'd14, 16'd2);
    drive_start(MODE_INT, 16'd100, 16'd7);
    check("t1_state_shift", dbg_state, SHIFT);
    wait_rdy(1, lat, wok);
    check("t1_latency", lat, 65);
    check("t1_work_busy", wok, 1'b1);
    check("t1_work_fin", bus.work, 1'b0);
    check_op("t1");
    check("t1_dz", bus.dz, 1'b0);
    check("t1_ovf", bus.ovf, 1'b0);
    @(posedge clk);
    #1;
    check("t1_rdy_pulse", bus.rdy, 1'b0);
    check("t1_hold_result", bus.result, 16'd14);
    check("t1_idle", dbg_state, IDLE);

    // Q0.16: 0x4000/0x8000 = 0.5 -> 0x8000
    expect_op(16'h8000, 16'h0000);
    drive_start(MODE_Q16, 16'h4000, 16'h8000);
    check("t2_cleared", bus.result, 16'd0);
    wait_rdy(1, lat, wok);
    check("t2_latency", lat, 65);
    check_op("t2");
    check("t2_ovf", bus.ovf, 1'b0);
    @(posedge clk);
    #1;

    // Q0.16 overflow: 0x8000/0x4000 = 2.0 -> saturate
    expect_op(16'hFFFF, 16'h0000);
    drive_start(MODE_Q16, 16'h8000, 16'h4000);
    wait_rdy(1, lat, wok);
    check("t3_latency", lat, 65);
    check_op("t3");
    check("t3_ovf", bus.ovf, 1'b1);
    check("t3_dz", bus.dz, 1'b0);
    @(posedge clk);
    #1;
    check("t3_hold_ovf", bus.ovf, 1'b1);

    // divide by zero
    expect_op(16'hFFFF, 16'd1234);
    drive_start(MODE_INT, 16'd1234, 16'd0);
    wait_rdy(1, lat, wok);
    check("t4_latency", lat, 1);
    check_op("t4");
    check("t4_dz", bus.dz, 1'b1);
    check("t4_ovf", bus.ovf, 1'b0);
    @(posedge clk);
    #1;
    check("t4_rdy_pulse", bus.rdy, 1'b0);
    check("t4_hold_dz", bus.dz, 1'b1);

    // start with new operands while busy is ignored
    expect_op(16'd14, 16'd2);
    drive_start(MODE_INT, 16'd100, 16'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.num1 = 16'd5;
    bus.num2 = 16'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_rdy(11, lat, wok);
    check("t5_latency", lat, 65);
    check_op("t5");
    @(posedge clk);
    #1;
    expect_op(16'd5, 16'd0);
    drive_start(MODE_INT, 16'd5, 16'd1);
    wait_rdy(1, lat, wok);
    check("t5b_latency", lat, 65);
    check_op("t5b");

    // reset in the middle of an operation
    @(posedge clk);
    #1;
    drive_start(MODE_INT, 16'd100, 16'd7);
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_result", bus.result, 16'd0);
    check("t6_remainder", bus.remainder, 16'd0);
    check("t6_work", bus.work, 1'b0);
    check("t6_rdy", bus.rdy, 1'b0);
    check("t6_state", dbg_state, IDLE);
    saw_rdy = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.rdy === 1'b1) saw_rdy = 1'b1;
    end
    check("t6_no_rdy", saw_rdy, 1'b0);
    expect_op(16'd257, 16'd0);
    drive_start(MODE_INT, 16'd65535, 16'd255);
    wait_rdy(1, lat, wok);
    check("t6b_latency", lat, 65);
    check_op("t6b");
    check("t6b_dz", bus.dz, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
